mem_arbiter: RTL

Arbiter and sequencer for the single-port shared memory (`memoria_compartilhada`) in the pipelined MIPS CPU. It serves two requesters: instruction fetch (IF, read-only) and the data-memory stage (DM, read/write). The block grants one access at a time and drives the memory strobes for a fixed access latency. It returns read data with a one-cycle done pulse, which the pipeline uses as its stall release. DM has priority, and a streak limit prevents fetch starvation.

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter/sequencer for the MIPS pipeline: grants IF or DM one access at a time,
// holds the memory strobes for LATENCY cycles and returns registered read data with a done pulse.
//
// state  | meaning
// IDLE   | sample requests, grant one (DM priority, bounded by the streak limit)
// ACCESS | strobes asserted, latency counter runs down to zero
// RESP   | owner's done pulse, strobes low, back to IDLE next cycle
module mem_arbiter #(
  parameter int LATENCY       = 2,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        lerMem,
  output logic        escMem,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW = (MAX_DM_STREAK > 1) ? $clog2(MAX_DM_STREAK + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD   = CW'(LATENCY - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic        owner_dm_q, owner_dm_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        ler_q, ler_d;
  logic        esc_q, esc_d;
  logic        if_done_q, if_done_d;
  logic        dm_done_q, dm_done_d;
  logic        grant_dm;

  // IF wins a contended grant only once DM has hit its streak limit
  assign grant_dm = dm_req && !(if_req && (streak_q == STREAK_MAX));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      streak_q   <= '0;
      owner_dm_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      ler_q      <= 1'b0;
      esc_q      <= 1'b0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      owner_dm_q <= owner_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      ler_q      <= ler_d;
      esc_q      <= esc_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    owner_dm_d = owner_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    ler_d      = 1'b0;
    esc_d      = 1'b0;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d = ACCESS;
          cnt_d   = CNT_LOAD;
          if (grant_dm) begin
            owner_dm_d = 1'b1;
            we_d       = dm_we;
            addr_d     = dm_addr;
            wdata_d    = dm_wdata;
            ler_d      = !dm_we;
            esc_d      = dm_we;
            if (!if_req)                    streak_d = '0;
            else if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
          end else begin
            owner_dm_d = 1'b0;
            we_d       = 1'b0;
            addr_d     = if_addr;
            ler_d      = 1'b1;
            streak_d   = '0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (owner_dm_q) begin
            dm_done_d = 1'b1;
            if (!we_q) dm_rdata_d = mem_rdata;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          ler_d = ler_q;
          esc_d = esc_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_done   = dm_done_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign lerMem    = ler_q;
  assign escMem    = esc_q;

endmodule
